// File: rtl/dmem_wb_bridge_if.sv
// dmem_wb_bridge_if: pipelined Wishbone bus between the data bridge and memory.
// The master owns the cycle; the slave answers with ack/err and may stall.
interface dmem_wb_bridge_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_addr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_stall;

    modport master (
        output wb_cyc,
        output wb_stb,
        output wb_we,
        output wb_sel,
        output wb_addr,
        output wb_dat_o,
        input  wb_dat_i,
        input  wb_ack,
        input  wb_err,
        input  wb_stall
    );

    modport slave (
        input  wb_cyc,
        input  wb_stb,
        input  wb_we,
        input  wb_sel,
        input  wb_addr,
        input  wb_dat_o,
        output wb_dat_i,
        output wb_ack,
        output wb_err,
        output wb_stall
    );
endinterface

// File: rtl/dmem_wb_bridge.sv
// dmem_wb_bridge: core data port to a pipelined Wishbone master.
// One access in flight; misaligned accesses fault without touching the bus.
module dmem_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dmem_req,
    input  logic             dmem_cmd,
    input  logic [1:0]       dmem_width,
    input  logic [31:0]      dmem_addr,
    input  logic [31:0]      dmem_wdata,
    output logic [31:0]      dmem_rdata,
    output logic             dmem_resp,
    output logic             dmem_err,
    dmem_wb_bridge_if.master wb
);

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_q;
    logic [1:0]  width_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        misal;
    logic        hit;
    logic        fin;
    logic        fail;
    logic        bus_on;
    logic        stb_on;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] lane;

    // Lane steering from the latched access size and low address bits
    always_comb begin
        sel   = 4'b0000;
        wdat  = 32'h0;
        lane  = 32'h0;
        misal = 1'b0;
        unique case (1'b1)
            width_q == 2'b00: begin
                sel  = 4'b0001 << addr_q[1:0];
                wdat = {4{wdata_q[7:0]}};
                lane = {24'h0,
                        wb.wb_dat_i[{addr_q[1:0], 3'b000} +: 8]};
            end
            width_q == 2'b01: begin
                misal = addr_q[0];
                sel   = addr_q[1] ? 4'b1100 : 4'b0011;
                wdat  = {2{wdata_q[15:0]}};
                lane  = {16'h0, addr_q[1] ? wb.wb_dat_i[31:16]
                                          : wb.wb_dat_i[15:0]};
            end
            width_q == 2'b10: begin
                misal = addr_q[1:0] != 2'b00;
                sel   = 4'b1111;
                wdat  = wdata_q;
                lane  = wb.wb_dat_i;
            end
            default: misal = 1'b1;
        endcase
    end

    assign cnt_inc = cnt_q + 16'd1;
    assign hit     = wb.wb_ack | wb.wb_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        bus_on  = 1'b0;
        stb_on  = 1'b0;
        fin     = 1'b0;
        fail    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dmem_req) begin
                    state_d = REQ;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (misal) begin
                    fin  = 1'b1;
                    fail = 1'b1;
                end else begin
                    bus_on = 1'b1;
                    stb_on = 1'b1;
                    cnt_d  = cnt_inc;
                    // Responses during a stalled strobe are not ours yet
                    if (!wb.wb_stall && hit) begin
                        fin  = 1'b1;
                        fail = wb.wb_err;
                    end else if (cnt_inc == TMO) begin
                        fin  = 1'b1;
                        fail = 1'b1;
                    end else if (!wb.wb_stall) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                bus_on = 1'b1;
                cnt_d  = cnt_inc;
                if (hit) begin
                    fin  = 1'b1;
                    fail = wb.wb_err;
                end else if (cnt_inc == TMO) begin
                    fin  = 1'b1;
                    fail = 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fin) begin
            state_d = RESP;
            err_d   = fail;
            rdata_d = (fail | cmd_q) ? 32'h0 : lane;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= 1'b0;
            width_q <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= 16'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (state_q == IDLE && dmem_req) begin
                cmd_q   <= dmem_cmd;
                width_q <= dmem_width;
                addr_q  <= dmem_addr;
                wdata_q <= dmem_wdata;
            end
        end
    end

    assign wb.wb_cyc   = bus_on;
    assign wb.wb_stb   = stb_on;
    assign wb.wb_we    = bus_on & cmd_q;
    assign wb.wb_sel   = bus_on ? sel : 4'b0000;
    assign wb.wb_addr  = bus_on ? {addr_q[31:2], 2'b00} : 32'h0;
    assign wb.wb_dat_o = bus_on ? wdat : 32'h0;

    assign dmem_resp  = state_q == RESP;
    assign dmem_err   = dmem_resp & err_q;
    assign dmem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_wb_bridge.sv
// tb_dmem_wb_bridge: directed transactions against a transaction-level model.
// Outputs are compared on every falling edge while a transaction runs.
module tb_dmem_wb_bridge;

    localparam int T = 4;

    logic        clk;
    logic        rst_n;
    logic        dmem_req;
    logic        dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        dmem_err;

    dmem_wb_bridge_if wb ();

    dmem_wb_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmem_req   (dmem_req),
        .dmem_cmd   (dmem_cmd),
        .dmem_width (dmem_width),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .dmem_err   (dmem_err),
        .wb         (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 ack, 1 err, 2 ack+err, 3 silent
    typedef struct {
        logic        cmd;
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] di;
        int          stall;
        int          dly;
        int          kind;
        bit          spur;
        bit          late;
    } txn_t;

    typedef struct {
        int          nbus;
        int          nstb;
        int          resp_at;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] dat;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    int          nvec = 0;
    int          nerr = 0;
    int          cur = 0;
    bit          chk_en = 0;
    bit          done = 0;
    txn_t        cur_t;
    exp_t        ex;
    logic [31:0] prev_rd = 0;
    logic [31:0] last_rd = 0;

    int          s_cyc, s_stb, s_resp, s_rk;
    logic        s_err;
    logic [3:0]  s_sel;
    logic [31:0] s_addr, s_dat;

    function automatic txn_t mk(logic cmd, logic [1:0] w,
                                logic [31:0] a, logic [31:0] wd,
                                logic [31:0] di, int stall, int dly,
                                int kind, bit spur, bit late);
        txn_t t;
        t.cmd = cmd; t.w = w; t.a = a; t.wd = wd; t.di = di;
        t.stall = stall; t.dly = dly; t.kind = kind;
        t.spur = spur; t.late = late;
        return t;
    endfunction

    function automatic exp_t model(txn_t t);
        exp_t        e;
        bit          mis;
        int          r;
        logic [31:0] lanes;
        mis = (t.w == 2'b11) || (t.w == 2'b01 && t.a[0])
           || (t.w == 2'b10 && t.a[1:0] != 2'b00);
        e.sel = 4'h0; e.dat = 32'h0; lanes = 32'h0;
        e.addr = t.a & ~32'h3;
        case (t.w)
            2'b00: begin
                e.sel = 4'(1 << t.a[1:0]);
                e.dat = t.wd[7:0] * 32'h01010101;
                lanes = (t.di >> (8 * t.a[1:0])) & 32'hFF;
            end
            2'b01: begin
                e.sel = t.a[1] ? 4'hC : 4'h3;
                e.dat = t.wd[15:0] * 32'h00010001;
                lanes = (t.di >> (16 * t.a[1])) & 32'hFFFF;
            end
            2'b10: begin
                e.sel = 4'hF; e.dat = t.wd; lanes = t.di;
            end
            default: ;
        endcase
        if (mis) begin
            e.nbus = 0; e.nstb = 0; e.resp_at = 2;
            e.err = 1'b1; e.rdata = 32'h0;
        end else begin
            r = (t.kind == 3) ? T + 100 : t.stall + 1 + t.dly;
            if (r <= T) begin
                e.nbus = r; e.err = (t.kind != 0);
            end else begin
                e.nbus = T; e.err = 1'b1;
            end
            e.nstb = (t.stall + 1 < e.nbus) ? t.stall + 1 : e.nbus;
            e.resp_at = e.nbus + 1;
            e.rdata = (t.cmd || e.err) ? 32'h0 : lanes;
        end
        return e;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d: got %h expected %h",
                     n, cur, act, exp);
        end
    endtask

    task automatic compare();
        bit ecyc, estb, eresp;
        ecyc  = cur >= 1 && cur <= ex.nbus;
        estb  = cur >= 1 && cur <= ex.nstb;
        eresp = cur == ex.resp_at;
        if (cur == 0) begin
            s_cyc = 0; s_stb = 0; s_resp = 0; s_rk = 0;
            s_err = 0; s_sel = 0; s_addr = 0; s_dat = 0;
        end
        chk("wb_cyc", wb.wb_cyc, ecyc);
        chk("wb_stb", wb.wb_stb, estb);
        chk("dmem_resp", dmem_resp, eresp);
        chk("dmem_err", dmem_err, eresp ? ex.err : 1'b0);
        chk("dmem_rdata", dmem_rdata,
            cur >= ex.resp_at ? ex.rdata : prev_rd);
        if (ecyc) begin
            chk("wb_sel", wb.wb_sel, ex.sel);
            chk("wb_addr", wb.wb_addr, ex.addr);
            chk("wb_we", wb.wb_we, cur_t.cmd);
            if (cur_t.cmd) chk("wb_dat_o", wb.wb_dat_o, ex.dat);
        end else begin
            chk("wb_we_idle", wb.wb_we, 0);
        end
        if (wb.wb_cyc) begin
            s_cyc++;
            s_sel = wb.wb_sel; s_addr = wb.wb_addr; s_dat = wb.wb_dat_o;
        end
        if (wb.wb_stb) s_stb++;
        if (dmem_resp) begin
            s_resp++; s_rk = cur; s_err = dmem_err;
        end
    endtask

    task automatic bus_idle();
        wb.wb_stall = 0; wb.wb_ack = 0; wb.wb_err = 0; wb.wb_dat_i = 0;
    endtask

    task automatic run(txn_t t);
        int r;
        bit hit;
        @(posedge clk); #1;
        prev_rd = last_rd;
        cur_t = t;
        ex = model(t);
        cur = 0;
        dmem_req = 1; dmem_cmd = t.cmd; dmem_width = t.w;
        dmem_addr = t.a; dmem_wdata = t.wd;
        bus_idle();
        chk_en = 1;
        r = (t.kind == 3) ? -1 : t.stall + 1 + t.dly;
        for (int k = 1; k <= ex.resp_at + 1; k++) begin
            @(posedge clk); #1;
            cur = k;
            // Held request with scrambled fields must be ignored
            dmem_req = (k <= ex.resp_at);
            dmem_cmd = ~t.cmd; dmem_width = ~t.w;
            dmem_addr = ~t.a; dmem_wdata = ~t.wd;
            if (ex.nbus > 0) begin
                hit = (k == r);
                wb.wb_stall = (k <= t.stall);
                wb.wb_ack = (hit && (t.kind == 0 || t.kind == 2))
                         || (t.spur && k <= t.stall)
                         || (t.late && k > T);
                wb.wb_err = hit && (t.kind == 1 || t.kind == 2);
                wb.wb_dat_i = t.di;
            end
        end
        last_rd = ex.rdata;
    endtask

    initial begin
        rst_n = 1; dmem_req = 0; dmem_cmd = 0; dmem_width = 0;
        dmem_addr = 0; dmem_wdata = 0;
        bus_idle();
        #1 rst_n = 0;
        #1;
        chk("rst_cyc", wb.wb_cyc, 0);
        chk("rst_stb", wb.wb_stb, 0);
        chk("rst_we", wb.wb_we, 0);
        chk("rst_sel", wb.wb_sel, 0);
        chk("rst_addr", wb.wb_addr, 0);
        chk("rst_dat", wb.wb_dat_o, 0);
        chk("rst_resp", dmem_resp, 0);
        chk("rst_err", dmem_err, 0);
        chk("rst_rdata", dmem_rdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        fork
            begin : drv
                run(mk(0, 2'b00, 32'h1003, 0, 32'hAABBCCDD, 0, 1, 0, 0, 0));
                chk("p_byte_sel", s_sel, 4'b1000);
                chk("p_byte_addr", s_addr, 32'h1000);
                chk("p_byte_rdata", dmem_rdata, 32'h000000AA);
                chk("p_byte_err", s_err, 0);

                run(mk(1, 2'b01, 32'h2002, 32'h0000BEEF, 0, 3, 0, 0, 1, 0));
                chk("p_half_stb", s_stb, 4);
                chk("p_half_sel", s_sel, 4'b1100);
                chk("p_half_dat", s_dat, 32'hBEEFBEEF);
                chk("p_half_resp", s_resp, 1);

                run(mk(0, 2'b10, 32'h3001, 0, 32'h12345678, 0, 0, 0, 0, 0));
                chk("p_mis_cyc", s_cyc, 0);
                chk("p_mis_err", s_err, 1);
                chk("p_mis_rk", s_rk, 2);
                chk("p_mis_rdata", dmem_rdata, 0);

                run(mk(0, 2'b10, 32'h4000, 0, 32'h55AA55AA, 0, 0, 3, 0, 1));
                chk("p_tmo_cyc", s_cyc, 4);
                chk("p_tmo_err", s_err, 1);
                chk("p_tmo_resp", s_resp, 1);

                run(mk(1, 2'b10, 32'h5000, 32'h12345678, 0, 0, 0, 1, 0, 0));
                chk("p_werr_err", s_err, 1);
                chk("p_werr_dat", s_dat, 32'h12345678);

                run(mk(0, 2'b10, 32'h6004, 0, 32'hDEADBEEF, 0, 0, 2, 0, 0));
                chk("p_both_err", s_err, 1);
                chk("p_both_rdata", dmem_rdata, 0);

                run(mk(0, 2'b01, 32'h7002, 0, 32'h11223344, 0, 0, 0, 0, 0));
                chk("p_min_rk", s_rk, 2);
                chk("p_min_rdata", dmem_rdata, 32'h00001122);

                run(mk(0, 2'b01, 32'h7000, 0, 32'h11223344, 1, 1, 0, 0, 0));
                chk("p_hlo_rdata", dmem_rdata, 32'h00003344);
                chk("p_hlo_rk", s_rk, 4);

                run(mk(0, 2'b00, 32'h8001, 0, 32'h11223344, 0, 2, 0, 0, 0));
                chk("p_b1_rdata", dmem_rdata, 32'h00000033);

                run(mk(1, 2'b00, 32'h9002, 32'h000000A5, 0, 0, 0, 0, 0, 0));
                chk("p_bw_dat", s_dat, 32'hA5A5A5A5);
                chk("p_bw_sel", s_sel, 4'b0100);

                run(mk(1, 2'b11, 32'h9000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
                chk("p_w11_cyc", s_cyc, 0);
                run(mk(0, 2'b01, 32'h0001, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0));
                chk("p_h1_err", s_err, 1);

                run(mk(0, 2'b10, 32'hA100, 0, 32'h0F0F0F0F, 4, 0, 0, 0, 0));
                chk("p_stmo_stb", s_stb, 4);
                chk("p_stmo_err", s_err, 1);

                run(mk(0, 2'b10, 32'hA000, 0, 32'hCAFEF00D, 0, 3, 0, 0, 0));
                chk("p_edge_rdata", dmem_rdata, 32'hCAFEF00D);
                chk("p_edge_rk", s_rk, 5);

                // Reset while the bus cycle is waiting on its ack
                @(posedge clk); #1;
                chk_en = 0;
                dmem_req = 1; dmem_cmd = 0; dmem_width = 2'b10;
                dmem_addr = 32'hB000; bus_idle();
                @(posedge clk); #1;
                dmem_req = 0;
                @(posedge clk); #1;
                chk("r_wait_cyc", wb.wb_cyc, 1);
                #2 rst_n = 0;
                #1;
                chk("r_async_cyc", wb.wb_cyc, 0);
                chk("r_async_stb", wb.wb_stb, 0);
                chk("r_async_we", wb.wb_we, 0);
                chk("r_async_resp", dmem_resp, 0);
                chk("r_async_rdata", dmem_rdata, 0);
                repeat (2) @(posedge clk);
                #1 rst_n = 1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("r_post_resp", dmem_resp, 0);
                    chk("r_post_cyc", wb.wb_cyc, 0);
                end
                last_rd = 0;

                run(mk(1, 2'b10, 32'hC000, 32'h0BADF00D, 0, 0, 0, 0, 0, 0));
                chk("p_post_rk", s_rk, 2);
                chk("p_post_err", s_err, 0);
                run(mk(0, 2'b00, 32'hC002, 0, 32'h00770000, 0, 0, 0, 0, 0));
                chk("p_post_rdata", dmem_rdata, 32'h00000077);

                @(posedge clk); #1;
                done = 1;
            end
            begin : cmp
                while (!done) begin
                    @(negedge clk);
                    if (chk_en && !done) compare();
                end
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dmem_wb_bridge.md
DMEM_WB_BRIDGE -- requirements
Module: dmem_wb_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, bus cycles to wait for wb_ack/wb_err before aborting; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 dmem_req  input  1  core data request; sampled only in IDLE.
REQ-005 dmem_cmd  input  1  1=write, 0=read.
REQ-006 dmem_width  input  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-007 dmem_addr  input  32  byte address.
REQ-008 dmem_wdata  input  32  write data, right-aligned.
REQ-009 dmem_rdata  output  32  read data, right-aligned, zero-extended; core sign-extends.
REQ-010 dmem_resp  output  1  one-cycle completion pulse.
REQ-011 dmem_err  output  1  valid with dmem_resp; 1=access failed.
REQ-012 wb_cyc, wb_stb, wb_we  output  1 each  pipelined Wishbone master controls.
REQ-013 wb_sel  output  4  byte lane enables.
REQ-014 wb_addr  output  32  word address {addr[31:2],2'b00}.
REQ-015 wb_dat_o  output  32  lane-replicated write data.
REQ-016 wb_dat_i  input  32;  wb_ack, wb_err, wb_stall  input  1 each.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, RESP; one transaction outstanding at most.
REQ-018 IDLE with dmem_req=1 SHALL latch cmd/width/addr/wdata and go to REQ next edge; request inputs are ignored in all other states.
REQ-019 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0, width=11) SHALL skip the bus and go to RESP with err=1.
REQ-020 wb_sel: byte=4'b0001<<addr[1:0]; half=addr[1]?4'b1100:4'b0011; word=4'b1111.
REQ-021 wb_dat_o: byte={4{wdata[7:0]}}; half={2{wdata[15:0]}}; word=wdata.
REQ-022 REQ: wb_cyc=wb_stb=1; stay while wb_stall=1; leave to WAIT on wb_stall=0 (wb_stb drops next cycle).
REQ-023 wb_ack or wb_err sampled in REQ with wb_stall=0 or in WAIT SHALL complete the cycle: capture wb_dat_i lanes, go to RESP.
REQ-024 WAIT: wb_cyc=1, wb_stb=0; wb_ack/wb_err while wb_stb=1 and wb_stall=1 SHALL be ignored.
REQ-025 wb_ack and wb_err together SHALL be treated as error.
REQ-026 16-bit counter clears on entering REQ, increments each REQ/WAIT cycle; reaching TIMEOUT_CYCLES SHALL drop wb_cyc and go to RESP with err=1.
REQ-027 RESP: dmem_resp=1 for exactly one cycle, wb_cyc=0, then IDLE; new request accepted no earlier than the cycle after RESP.
REQ-028 Minimum latency: req sampled edge N, stb high cycle N+1, ack cycle N+1 -> dmem_resp cycle N+2.
REQ-029 dmem_rdata: byte=wb_dat_i lane addr[1:0] in [7:0]; half=selected 16-bit lane in [15:0]; upper bits 0; held until next RESP; 0 for writes and errors.
REQ-030 wb_we SHALL equal latched cmd while wb_cyc=1, else 0.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, all outputs 0, counter 0, latched fields 0, including mid-transaction (wb_cyc drops asynchronously).
REQ-032 First request after rst_n rises SHALL be accepted on the first clk edge with dmem_req=1.

Verification
REQ-033 Byte read addr 0x1003, wb_dat_i=0xAABBCCDD, ack one cycle after stb -> wb_sel=1000, wb_addr=0x1000, dmem_rdata=0x000000AA, err=0.
REQ-034 Half write addr 0x2002, wdata=0x0000BEEF, wb_stall high 3 cycles -> stb held 4 cycles, wb_sel=1100, wb_dat_o=0xBEEFBEEF, single resp.
REQ-035 Word read addr 0x3001 -> no wb_cyc, dmem_resp+dmem_err next-but-one cycle, rdata=0.
REQ-036 TIMEOUT_CYCLES=4, no ack -> wb_cyc drops after 4 bus cycles, resp with err=1; late ack ignored.
REQ-037 wb_err on word write -> resp with err=1; simultaneous ack+err -> err=1.
REQ-038 rst_n low during WAIT -> wb_cyc=0 without waiting for clk; no dmem_resp after release.
